// File: rtl/hf_reader_seq.sv
// HF reader sequencer: transmits a pause-modulated command, waits the frame
// delay guard time, then listens and assembles LSB-first bytes from the demodulator.
module hf_reader_seq #(
    parameter int unsigned BIT_TICKS  = 16,
    parameter int unsigned QUIET_BITS = 8
) (
    input  logic        osc_clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [5:0]  tx_len,
    input  logic [31:0] tx_bits,
    input  logic [11:0] fdt_ticks,
    input  logic [15:0] rx_timeout,
    input  logic        curbit,
    output logic [2:0]  mod_type,
    output logic        mod_sig_coil,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    output logic        busy,
    output logic        done,
    output logic        timed_out
);
    localparam int unsigned TW = $clog2(BIT_TICKS);
    localparam int unsigned QW = $clog2(QUIET_BITS + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(BIT_TICKS / 2);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [QW-1:0] QUIET_END = QW'(QUIET_BITS);
    localparam logic [QW-1:0] QUIET_ONE = QW'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_TX     = 2'd1;
    localparam logic [1:0] S_GUARD  = 2'd2;
    localparam logic [1:0] S_LISTEN = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [31:0]   tx_bits_q, tx_bits_d;
    logic [5:0]    tx_len_q, tx_len_d;
    logic [11:0]   fdt_q, fdt_d;
    logic [15:0]   rx_to_q, rx_to_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [5:0]    bit_q, bit_d;
    logic [11:0]   guard_q, guard_d;
    logic [15:0]   idle_q, idle_d;
    logic [QW-1:0] quiet_q, quiet_d;
    logic          active_q, active_d;
    logic          pend_q, pend_d;
    logic          exit_q, exit_d;
    logic [2:0]    mod_type_q, mod_type_d;
    logic          mod_sig_coil_q, mod_sig_coil_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_valid_q, rx_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          timed_out_q, timed_out_d;
    logic          shift_en;

    always_comb begin
        state_d        = state_q;
        tx_bits_d      = tx_bits_q;
        tx_len_d       = tx_len_q;
        fdt_d          = fdt_q;
        rx_to_d        = rx_to_q;
        tick_d         = tick_q;
        bit_d          = bit_q;
        guard_d        = guard_q;
        idle_d         = idle_q;
        quiet_d        = quiet_q;
        active_d       = active_q;
        pend_d         = pend_q;
        exit_d         = exit_q;
        mod_sig_coil_d = mod_sig_coil_q;
        rx_byte_d      = rx_byte_q;
        rx_valid_d     = 1'b0;
        done_d         = 1'b0;
        timed_out_d    = 1'b0;
        shift_en       = 1'b0;

        if (abort) begin
            state_d        = S_IDLE;
            mod_sig_coil_d = 1'b0;
            tick_d         = '0;
            bit_d          = '0;
            guard_d        = '0;
            idle_d         = '0;
            quiet_d        = '0;
            active_d       = 1'b0;
            pend_d         = 1'b0;
            exit_d         = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        tx_bits_d = tx_bits;
                        tx_len_d  = (tx_len > 6'd32) ? 6'd32 : tx_len;
                        fdt_d     = fdt_ticks;
                        rx_to_d   = rx_timeout;
                        tick_d    = '0;
                        bit_d     = '0;
                        guard_d   = '0;
                        if (tx_len != 6'd0) begin
                            state_d        = S_TX;
                            mod_sig_coil_d = tx_bits[0];
                        end else begin
                            state_d = S_GUARD;
                        end
                    end
                end
                S_TX: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (bit_q == tx_len_q - 6'd1) begin
                            state_d        = S_GUARD;
                            mod_sig_coil_d = 1'b0;
                            bit_d          = '0;
                            guard_d        = '0;
                        end else begin
                            bit_d          = bit_q + 6'd1;
                            mod_sig_coil_d = tx_bits_q[bit_q[4:0] + 5'd1];
                        end
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
                S_GUARD: begin
                    if (fdt_q == 12'd0 || guard_q == fdt_q - 12'd1) begin
                        state_d   = S_LISTEN;
                        tick_d    = '0;
                        bit_d     = '0;
                        idle_d    = '0;
                        quiet_d   = '0;
                        active_d  = 1'b0;
                        pend_d    = 1'b0;
                        exit_d    = 1'b0;
                        rx_byte_d = '0;
                    end else begin
                        guard_d = guard_q + 12'd1;
                    end
                end
                S_LISTEN: begin
                    // done/timed_out pulse while still in LISTEN; IDLE follows one cycle later.
                    // A byte completing on the frame-ending sample defers done by one cycle.
                    if (exit_q) begin
                        state_d = S_IDLE;
                        exit_d  = 1'b0;
                    end else if (pend_q) begin
                        done_d = 1'b1;
                        pend_d = 1'b0;
                        exit_d = 1'b1;
                    end else begin
                        tick_d   = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_ONE;
                        shift_en = (tick_q == TICK_MID) && (active_q || curbit);
                        if (shift_en) begin
                            active_d  = 1'b1;
                            rx_byte_d = {curbit, rx_byte_q[7:1]};
                            if (bit_q == 6'd7) begin
                                rx_valid_d = 1'b1;
                                bit_d      = '0;
                            end else begin
                                bit_d = bit_q + 6'd1;
                            end
                            if (curbit) begin
                                quiet_d = '0;
                            end else if (quiet_q + QUIET_ONE == QUIET_END) begin
                                quiet_d = '0;
                                if (bit_q == 6'd7) begin
                                    pend_d = 1'b1;
                                end else begin
                                    done_d = 1'b1;
                                    exit_d = 1'b1;
                                end
                            end else begin
                                quiet_d = quiet_q + QUIET_ONE;
                            end
                        end else if (!active_q) begin
                            idle_d = (idle_q == '1) ? idle_q : idle_q + 16'd1;
                            if (rx_to_q != 16'd0 && idle_d == rx_to_q) begin
                                timed_out_d = 1'b1;
                                exit_d      = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_IDLE:  mod_type_d = 3'b000;
            S_TX:    mod_type_d = 3'b100;
            default: mod_type_d = 3'b011;
        endcase
    end

    always_ff @(negedge osc_clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            tx_bits_q      <= '0;
            tx_len_q       <= '0;
            fdt_q          <= '0;
            rx_to_q        <= '0;
            tick_q         <= '0;
            bit_q          <= '0;
            guard_q        <= '0;
            idle_q         <= '0;
            quiet_q        <= '0;
            active_q       <= 1'b0;
            pend_q         <= 1'b0;
            exit_q         <= 1'b0;
            mod_type_q     <= 3'b000;
            mod_sig_coil_q <= 1'b0;
            rx_byte_q      <= '0;
            rx_valid_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            timed_out_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            tx_bits_q      <= tx_bits_d;
            tx_len_q       <= tx_len_d;
            fdt_q          <= fdt_d;
            rx_to_q        <= rx_to_d;
            tick_q         <= tick_d;
            bit_q          <= bit_d;
            guard_q        <= guard_d;
            idle_q         <= idle_d;
            quiet_q        <= quiet_d;
            active_q       <= active_d;
            pend_q         <= pend_d;
            exit_q         <= exit_d;
            mod_type_q     <= mod_type_d;
            mod_sig_coil_q <= mod_sig_coil_d;
            rx_byte_q      <= rx_byte_d;
            rx_valid_q     <= rx_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            timed_out_q    <= timed_out_d;
        end
    end

    assign mod_type     = mod_type_q;
    assign mod_sig_coil = mod_sig_coil_q;
    assign rx_byte      = rx_byte_q;
    assign rx_valid     = rx_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign timed_out    = timed_out_q;

endmodule

// File: tb/tb_hf_reader_seq.sv
// Directed bench for hf_reader_seq: TX pattern, guard, timeout, receive, abort and reset.
module tb_hf_reader_seq;
    logic        osc_clk = 1'b1;
    logic        rst;
    logic        start;
    logic        abort;
    logic [5:0]  tx_len;
    logic [31:0] tx_bits;
    logic [11:0] fdt_ticks;
    logic [15:0] rx_timeout;
    logic        curbit;
    logic [2:0]  mod_type;
    logic        mod_sig_coil;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        busy;
    logic        done;
    logic        timed_out;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // DUT acts on negedge; the bench drives and samples on posedge.
    always #5 osc_clk = ~osc_clk;

    hf_reader_seq #(
        .BIT_TICKS (16),
        .QUIET_BITS(8)
    ) dut (
        .osc_clk     (osc_clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .tx_len      (tx_len),
        .tx_bits     (tx_bits),
        .fdt_ticks   (fdt_ticks),
        .rx_timeout  (rx_timeout),
        .curbit      (curbit),
        .mod_type    (mod_type),
        .mod_sig_coil(mod_sig_coil),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .busy        (busy),
        .done        (done),
        .timed_out   (timed_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // Issues a start and follows TX, GUARD and a timed-out LISTEN cycle by cycle.
    task automatic run_frame(input logic [5:0] len, input logic [31:0] bits,
                             input logic [11:0] fdt, input logic [15:0] to, input bit inj);
        int unsigned eff_len, t_end, l_ent, t_out;
        logic exp_coil;
        eff_len = (len > 6'd32) ? 32 : int'(len);
        t_end   = eff_len * 16;
        l_ent   = t_end + ((fdt == 12'd0) ? 1 : int'(fdt));
        t_out   = l_ent + int'(to);
        curbit     = 1'b0;
        tx_len     = len;
        tx_bits    = bits;
        fdt_ticks  = fdt;
        rx_timeout = to;
        start      = 1'b1;
        @(posedge osc_clk);
        start = 1'b0;
        for (int i = 0; i <= int'(t_out) + 2; i++) begin
            exp_coil = (i < int'(t_end)) ? bits[i / 16] : 1'b0;
            check("coil", mod_sig_coil, exp_coil);
            check("mod_type", mod_type, (i < int'(t_end)) ? 32'd4 : ((i <= int'(t_out)) ? 32'd3 : 32'd0));
            check("busy", busy, (i <= int'(t_out)) ? 32'd1 : 32'd0);
            check("timed_out", timed_out, (i == int'(t_out)) ? 32'd1 : 32'd0);
            check("done", done, 32'd0);
            check("rx_valid", rx_valid, 32'd0);
            if (inj && i == int'(l_ent) + 20) begin
                start      = 1'b1;
                tx_len     = 6'd5;
                tx_bits    = '1;
                fdt_ticks  = 12'd7;
                rx_timeout = 16'd30;
            end else begin
                start = 1'b0;
            end
            @(posedge osc_clk);
        end
    endtask

    initial begin
        logic [17:0] rx_pat;
        rst = 1'b1; start = 1'b0; abort = 1'b0; curbit = 1'b0;
        tx_len = '0; tx_bits = '0; fdt_ticks = '0; rx_timeout = '0;

        // reset values, then no pulses right after release
        repeat (2) @(posedge osc_clk);
        check("rst mod_type", mod_type, 32'd0);
        check("rst coil", mod_sig_coil, 32'd0);
        check("rst rx_byte", rx_byte, 32'd0);
        check("rst rx_valid", rx_valid, 32'd0);
        check("rst busy", busy, 32'd0);
        check("rst done", done, 32'd0);
        check("rst timed_out", timed_out, 32'd0);
        rst = 1'b0;
        @(posedge osc_clk);
        check("post-rst pulses", {done, timed_out, rx_valid, busy}, 32'd0);

        // short TX frame 0x26/7 bits, 20-clock guard, timeout 10 after LISTEN entry
        run_frame(6'd7, 32'h26, 12'd20, 16'd10, 1'b0);
        // tx_len 0, timeout 100; a start mid-LISTEN must be ignored
        run_frame(6'd0, 32'h0, 12'd1, 16'd100, 1'b1);
        // tx_len above 32 clamps to 32, fdt 0 behaves as 1
        run_frame(6'd40, 32'h8000_0001, 12'd0, 16'd3, 1'b0);

        // receive: two quiet periods, 0xA5 LSB first, then eight quiet periods
        rx_pat = 18'h00294;
        tx_len = 6'd0; tx_bits = '0; fdt_ticks = 12'd1; rx_timeout = 16'd0;
        start = 1'b1;
        @(posedge osc_clk);
        start = 1'b0;
        for (int i = 0; i <= 290; i++) begin
            int m;
            check("rx rx_valid", rx_valid, (i == 154 || i == 282) ? 32'd1 : 32'd0);
            if (i == 154) check("rx byte A5", rx_byte, 32'hA5);
            if (i == 282) check("rx byte 00", rx_byte, 32'h00);
            check("rx done", done, (i == 283) ? 32'd1 : 32'd0);
            check("rx busy", busy, (i < 284) ? 32'd1 : 32'd0);
            check("rx timed_out", timed_out, 32'd0);
            m = (i == 0) ? 0 : (i - 1) / 16;
            curbit = (m < 18) ? rx_pat[m] : 1'b0;
            @(posedge osc_clk);
        end
        curbit = 1'b0;

        // abort during TX bit 3 of a 10-bit frame
        tx_len = 6'd10; tx_bits = 32'h2AD; fdt_ticks = 12'd5; rx_timeout = 16'd0;
        start = 1'b1;
        @(posedge osc_clk);
        start = 1'b0;
        repeat (50) @(posedge osc_clk);
        check("abort pre coil", mod_sig_coil, 32'd1);
        check("abort pre mod_type", mod_type, 32'd4);
        abort = 1'b1;
        @(posedge osc_clk);
        abort = 1'b0;
        check("abort coil", mod_sig_coil, 32'd0);
        check("abort mod_type", mod_type, 32'd0);
        check("abort busy", busy, 32'd0);
        for (int i = 0; i < 40; i++) begin
            check("abort pulses", {done, timed_out, rx_valid, busy}, 32'd0);
            @(posedge osc_clk);
        end
        // start and abort together in IDLE: abort wins
        start = 1'b1; abort = 1'b1;
        @(posedge osc_clk);
        start = 1'b0; abort = 1'b0;
        @(posedge osc_clk);
        check("start+abort busy", busy, 32'd0);
        run_frame(6'd2, 32'h1, 12'd3, 16'd5, 1'b0);

        // reset mid-TX clears the coil on that edge
        tx_len = 6'd4; tx_bits = 32'hF; fdt_ticks = 12'd2; rx_timeout = 16'd0;
        start = 1'b1;
        @(posedge osc_clk);
        start = 1'b0;
        repeat (20) @(posedge osc_clk);
        check("midtx coil", mod_sig_coil, 32'd1);
        rst = 1'b1;
        @(posedge osc_clk);
        check("midtx rst coil", mod_sig_coil, 32'd0);
        check("midtx rst mod_type", mod_type, 32'd0);
        check("midtx rst busy", busy, 32'd0);
        rst = 1'b0;
        @(posedge osc_clk);
        check("midtx post-rst", {done, timed_out, rx_valid, busy}, 32'd0);

        // reset mid-LISTEN after four shifted ones
        tx_len = 6'd0; fdt_ticks = 12'd1; rx_timeout = 16'd0; curbit = 1'b1;
        start = 1'b1;
        @(posedge osc_clk);
        start = 1'b0;
        repeat (60) @(posedge osc_clk);
        check("listen rx_byte", rx_byte, 32'hF0);
        check("listen busy", busy, 32'd1);
        rst = 1'b1;
        @(posedge osc_clk);
        check("listen rst outputs", {mod_type, mod_sig_coil, rx_byte, rx_valid, busy, done, timed_out}, 32'd0);
        rst = 1'b0; curbit = 1'b0;
        @(posedge osc_clk);
        check("listen post-rst", {done, timed_out, rx_valid, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
